pip_alu_arb: RTL and testbench
==============================

# pip_alu_arb

Two-requester round-robin arbiter and issue sequencer for the shared pipelined 4-bit ALU (`pip_ALU`). It accepts operand/opcode requests over valid/ready handshakes and registers the winner onto the ALU inputs. It tracks each in-flight operation with a tag delay line matched to the ALU latency, and returns `alu_x` to the originating requester on a per-requester response strobe.

## Interface
- `WIDTH`, 4: operand/result width
- `OPW`, 3: opcode width
- `LAT`, 3: ALU latency in cycles from registered inputs to valid `alu_x` (0 = combinational ALU)

- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous assert, active-low
- `req0_valid` / `req1_valid` in 1: request pending
- `req0_ready` / `req1_ready` out 1: grant this cycle (combinational)
- `req0_a`, `req0_b` / `req1_a`, `req1_b` in WIDTH: operands
- `req0_op` / `req1_op` in OPW: ALU opcode, passed through unmodified
- `hold` in 1: suppress new grants; in-flight operations continue
- `alu_a`, `alu_b` out WIDTH: registered ALU operands
- `alu_op` out OPW: registered ALU opcode
- `alu_x` in WIDTH: ALU result
- `rsp0_valid` / `rsp1_valid` out 1: one-cycle result strobe per requester
- `rsp_x` out WIDTH: result, valid when either `rspN_valid` is high
- `busy` out 1: at least one operation in flight

## Operation
- **Handshake.** A transfer occurs on requester i when `reqi_valid && reqi_ready`.
  - Requesters hold valid, operands and op stable until ready.
  - Dropping valid without a transfer is legal.
- **Grant.**
  - `hold=1`: both readies are 0.
  - Exactly one requester valid: that requester is granted.
  - Both valid: the grant goes to the one selected by the priority pointer `ptr`.
  - At most one ready is high per cycle.
  - Issue rate is at most one operation per cycle. There is no other backpressure, because the ALU is fully pipelined.
- **Pointer.** `ptr` resets to 0. After any grant to requester i, `ptr` becomes 1-i. Otherwise `ptr` holds. Alternating grants under continuous dual requests are therefore guaranteed.
- **Issue register.**
  - On a transfer, the granted a/b/op load into `alu_a`/`alu_b`/`alu_op` at the next edge.
  - With no transfer, they hold their previous value; the ALU output for those cycles is ignored.
- **Tag line.**
  - Shift register of depth LAT+1, each entry {vld, id}, shifting every cycle.
  - Stage 0 loads {transfer, granted id}.
  - The output entry drives `rsp_valid[id] = vld` and `rsp_x = alu_x`. When vld=0, `rsp_x` holds its last value.
- **Responses.** Responses are not backpressurable; requesters must sample them on the strobe. Results return in issue order.
- **busy.** OR of all tag-line vld bits.
- **Reset (any time, including mid-operation).**
  - All tag vld bits clear; outstanding operations are dropped with no response.
  - `ptr` = 0.
  - `alu_a`, `alu_b`, `alu_op`, `rsp_x` = 0.
  - `rsp0_valid`, `rsp1_valid`, `busy` = 0.
  - Readies are combinational: 0 while `rst_n` is low.

## Timing
- Handshake in cycle t: `alu_*` show the operands in cycle t+1, and `rspi_valid` is high in exactly cycle t+1+LAT.
- LAT=0: response in t+1.
- Back-to-back issues produce back-to-back responses, one per cycle, with no bubbles.
- `hold` takes effect in the same cycle: ready is combinational from `hold`.
- A transfer in cycle t and a response in the same cycle t are independent and both occur.
- Reset releases synchronously to `clk` at the system level. The first grant is possible in the first cycle with `rst_n` high.

## Structure
- Shared package `pip_alu_pkg`: WIDTH and OPW defaults, and opcode localparams for 000–111, so the ALU, arbiter and benches agree on the encoding.
- Sub-module `pip_alu_tagline`: parameterised by depth and id width, carrying {vld, id}, with asynchronous active-low clear.
- The arbiter does not instantiate `pip_ALU`. It connects at the parent level or in the bench.

## Test plan
- **Single request:** reset, `req0` a=0100 b=0110 op=010 with LAT=3. Required: `req0_ready`=1 in cycle t, `alu_a`=0100 at t+1, `rsp0_valid`=1 only at t+4 with `rsp_x` equal to the ALU result; `rsp1_valid` stays 0.
- **Round-robin:** both valid continuously for 6 cycles with distinct ops. Required: grants go 0,1,0,1,0,1, and responses alternate `rsp0`/`rsp1` from t+4 with no gaps and matching data.
- **Hold:** assert `hold` during dual requests for 3 cycles. Required: no readies and no new tags. In-flight responses still arrive, and `busy` falls after the last one. After release, the grant goes to the requester selected by `ptr`.
- **Reset mid-flight:** issue 3 operations, then pulse `rst_n` low 1 cycle later. Required: no `rsp_valid` ever appears for them, `busy`=0, `ptr`=0, and all `alu_*` outputs are 0.
- **Valid withdrawal and single-side stream:** `req1` holds valid for 8 cycles while `req0` is idle. Required: `req1` is granted every cycle. Then `req0` pulses valid for 1 cycle while `req1` has priority. Required: no transfer for `req0` and no spurious response.
- **LAT=0 build:** back-to-back ops 000–111 from `req0`. Required: each response arrives exactly 1 cycle after its handshake, in order.

Source files
------------

// File: rtl/pip_alu_pkg.sv
// Shared ALU encoding and sizing for the pip_ALU arbiter, the ALU and the benches.
// Keeps the opcode map and requester-id helpers in one place.
package pip_alu_pkg;

   localparam int WIDTH_DEF = 4;
   localparam int OPW_DEF   = 3;
   localparam int ID_W      = 1;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_NOTA = 3'b101;
   localparam logic [2:0] OP_SHLA = 3'b110;
   localparam logic [2:0] OP_PASB = 3'b111;

   // Round-robin hand-off: the requester that did not just win gets priority.
   function automatic logic [ID_W-1:0] other_id(input logic [ID_W-1:0] id);
      return ~id;
   endfunction

endpackage

// File: rtl/pip_alu_tagline.sv
// Tag delay line carrying {vld, id} alongside the pipelined ALU.
// Shifts every cycle; the last stage marks which requester owns alu_x.
module pip_alu_tagline #(
   parameter int DEPTH = 4,
   parameter int IDW   = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_vld,
   input  logic [IDW-1:0] in_id,
   output logic           out_vld,
   output logic [IDW-1:0] out_id,
   output logic           any_vld
);

   logic [DEPTH-1:0] vld_r;
   logic [IDW-1:0]   id_r [DEPTH];

   // Shift register: reset drops every outstanding operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_r <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            id_r[i] <= '0;
         end
      end else begin
         vld_r[0] <= in_vld;
         id_r[0]  <= in_id;
         for (int i = 1; i < DEPTH; i++) begin
            vld_r[i] <= vld_r[i-1];
            id_r[i]  <= id_r[i-1];
         end
      end
   end

   assign out_vld = vld_r[DEPTH-1];
   assign out_id  = id_r[DEPTH-1];
   assign any_vld = |vld_r;

endmodule

// File: rtl/pip_alu_arb.sv
// Two-requester round-robin arbiter and issue sequencer for the pipelined ALU.
// Registers the winner onto the ALU inputs and routes alu_x back after LAT cycles.
module pip_alu_arb
   import pip_alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int OPW   = OPW_DEF,
   parameter int LAT   = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [OPW-1:0]   req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [OPW-1:0]   req1_op,
   input  logic             hold,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [OPW-1:0]   alu_op,
   input  logic [WIDTH-1:0] alu_x,
   output logic             rsp0_valid,
   output logic             rsp1_valid,
   output logic [WIDTH-1:0] rsp_x,
   output logic             busy
);

   logic            gnt0_s;
   logic            gnt1_s;
   logic            xfer_s;
   logic [ID_W-1:0] gnt_id_s;
   logic [ID_W-1:0] ptr_r;
   logic            tag_vld_s;
   logic [ID_W-1:0] tag_id_s;
   logic            tag_any_s;
   logic [WIDTH-1:0] rsp_hold_r;

   // Grant decode: readies are combinational and forced low in reset or hold.
   always_comb begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
      if (!rst_n || hold) begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end else if (req0_valid && req1_valid) begin
         gnt0_s = (ptr_r == 1'b0);
         gnt1_s = (ptr_r == 1'b1);
      end else begin
         gnt0_s = req0_valid;
         gnt1_s = req1_valid;
      end
   end

   assign req0_ready = gnt0_s;
   assign req1_ready = gnt1_s;
   assign xfer_s     = gnt0_s | gnt1_s;
   assign gnt_id_s   = gnt1_s;

   // Priority pointer moves to the loser after every grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_r <= 1'b0;
      end else if (xfer_s) begin
         ptr_r <= other_id(gnt_id_s);
      end else begin
         ptr_r <= ptr_r;
      end
   end

   // Issue register: idle cycles keep the old operands, their ALU output is never claimed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a  <= '0;
         alu_b  <= '0;
         alu_op <= '0;
      end else if (xfer_s) begin
         alu_a  <= gnt1_s ? req1_a  : req0_a;
         alu_b  <= gnt1_s ? req1_b  : req0_b;
         alu_op <= gnt1_s ? req1_op : req0_op;
      end else begin
         alu_a  <= alu_a;
         alu_b  <= alu_b;
         alu_op <= alu_op;
      end
   end

   pip_alu_tagline #(
      .DEPTH (LAT + 1),
      .IDW   (ID_W)
   ) u_tagline (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_vld  (xfer_s),
      .in_id   (gnt_id_s),
      .out_vld (tag_vld_s),
      .out_id  (tag_id_s),
      .any_vld (tag_any_s)
   );

   // Last delivered result, presented on rsp_x between strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_hold_r <= '0;
      end else if (tag_vld_s) begin
         rsp_hold_r <= alu_x;
      end else begin
         rsp_hold_r <= rsp_hold_r;
      end
   end

   assign rsp0_valid = tag_vld_s & (tag_id_s == 1'b0);
   assign rsp1_valid = tag_vld_s & (tag_id_s == 1'b1);
   assign rsp_x      = tag_vld_s ? alu_x : rsp_hold_r;
   assign busy       = tag_any_s;

endmodule

// File: tb/tb_pip_alu_arb.sv
// Bench for pip_alu_arb: a LAT=3 and a LAT=0 instance share the requesters and are
// compared every cycle against a cycle-indexed response schedule.
module tb_pip_alu_arb;
   import pip_alu_pkg::*;

   localparam int MSK = 4095;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic hold = 1'b0;
   logic v0 = 1'b0, v1 = 1'b0;
   logic [3:0] a0 = 4'd0, b0 = 4'd0, a1 = 4'd0, b1 = 4'd0;
   logic [2:0] op0 = 3'd0, op1 = 3'd0;

   logic       rdy0_3, rdy1_3, rv0_3, rv1_3, busy3;
   logic [3:0] aa3, ab3, ax3, rx3;
   logic [2:0] aop3;
   logic       rdy0_0, rdy1_0, rv0_0, rv1_0, busy0;
   logic [3:0] aa0, ab0, ax0, rx0;
   logic [2:0] aop0;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_NOTA: return ~a;
         OP_SHLA: return {a[2:0], 1'b0};
         default: return b;
      endcase
   endfunction

   // ALU models: 3-stage pipe for the LAT=3 instance, combinational for LAT=0.
   logic [3:0] p3 [3];
   always @(posedge clk) begin
      p3[0] <= alu_f(aa3, ab3, aop3);
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign ax3 = p3[2];
   assign ax0 = alu_f(aa0, ab0, aop0);

   pip_alu_arb #(.WIDTH(4), .OPW(3), .LAT(3)) u3 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(v0), .req0_ready(rdy0_3), .req0_a(a0), .req0_b(b0), .req0_op(op0),
      .req1_valid(v1), .req1_ready(rdy1_3), .req1_a(a1), .req1_b(b1), .req1_op(op1),
      .hold(hold), .alu_a(aa3), .alu_b(ab3), .alu_op(aop3), .alu_x(ax3),
      .rsp0_valid(rv0_3), .rsp1_valid(rv1_3), .rsp_x(rx3), .busy(busy3));

   pip_alu_arb #(.WIDTH(4), .OPW(3), .LAT(0)) u0 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(v0), .req0_ready(rdy0_0), .req0_a(a0), .req0_b(b0), .req0_op(op0),
      .req1_valid(v1), .req1_ready(rdy1_0), .req1_a(a1), .req1_b(b1), .req1_op(op1),
      .hold(hold), .alu_a(aa0), .alu_b(ab0), .alu_op(aop0), .alu_x(ax0),
      .rsp0_valid(rv0_0), .rsp1_valid(rv1_0), .rsp_x(rx0), .busy(busy0));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
      end
   endtask

   // Reference model: priority pointer, issue values, and per-instance schedule of due responses.
   logic       m_ptr = 1'b0;
   logic [3:0] m_a = 4'd0, m_b = 4'd0;
   logic [2:0] m_op = 3'd0;
   logic       tv  [2][MSK+1];
   logic       tid [2][MSK+1];
   logic [3:0] tx  [2][MSK+1];
   logic [3:0] lx  [2];
   logic       e0, e1, xfer0_q = 1'b0, xfer1_q = 1'b0;

   initial begin
      for (int d = 0; d < 2; d++) begin
         lx[d] = 4'd0;
         for (int k = 0; k <= MSK; k++) tv[d][k] = 1'b0;
      end
   end

   task automatic chk_dut(input int d, input int lat, input logic r0, input logic r1, input logic [3:0] x,
                          input logic bz, input logic [3:0] aa, input logic [3:0] ab, input logic [2:0] aop);
      int  ix;
      logic ev, eb;
      ix = cyc & MSK;
      ev = rst_n && tv[d][ix];
      eb = 1'b0;
      for (int k = 0; k <= lat; k++) eb = eb | (rst_n && tv[d][(cyc + k) & MSK]);
      chk($sformatf("rsp0_valid[L%0d]", lat), r0, ev && !tid[d][ix]);
      chk($sformatf("rsp1_valid[L%0d]", lat), r1, ev && tid[d][ix]);
      if (ev) lx[d] = tx[d][ix];
      tv[d][ix] = 1'b0;
      chk($sformatf("rsp_x[L%0d]", lat), x, lx[d]);
      chk($sformatf("busy[L%0d]", lat), bz, eb);
      chk($sformatf("alu_a[L%0d]", lat), aa, m_a);
      chk($sformatf("alu_b[L%0d]", lat), ab, m_b);
      chk($sformatf("alu_op[L%0d]", lat), aop, m_op);
   endtask

   // Compare process: evaluates the model and checks both instances each cycle.
   always @(negedge clk) begin
      if (!rst_n) begin
         m_ptr = 1'b0; m_a = 4'd0; m_b = 4'd0; m_op = 3'd0;
         e0 = 1'b0; e1 = 1'b0;
         for (int d = 0; d < 2; d++) begin
            lx[d] = 4'd0;
            for (int k = 0; k < 8; k++) tv[d][(cyc + k) & MSK] = 1'b0;
         end
      end else if (hold) begin
         e0 = 1'b0; e1 = 1'b0;
      end else if (v0 && v1) begin
         e0 = (m_ptr == 1'b0); e1 = !e0;
      end else begin
         e0 = v0; e1 = v1;
      end
      chk("req0_ready[L3]", rdy0_3, e0);
      chk("req1_ready[L3]", rdy1_3, e1);
      chk("req0_ready[L0]", rdy0_0, e0);
      chk("req1_ready[L0]", rdy1_0, e1);
      chk_dut(0, 3, rv0_3, rv1_3, rx3, busy3, aa3, ab3, aop3);
      chk_dut(1, 0, rv0_0, rv1_0, rx0, busy0, aa0, ab0, aop0);
      if (e0 || e1) begin
         m_a  = e1 ? a1 : a0;
         m_b  = e1 ? b1 : b0;
         m_op = e1 ? op1 : op0;
         for (int d = 0; d < 2; d++) begin
            int k;
            k = (cyc + 1 + (d == 0 ? 3 : 0)) & MSK;
            tv[d][k]  = 1'b1;
            tid[d][k] = e1;
            tx[d][k]  = alu_f(m_a, m_b, m_op);
         end
         m_ptr = e0;
      end
      xfer0_q = e0;
      xfer1_q = e1;
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Requester protocol: new operands only when idle or just transferred.
   task automatic refresh(input int r, input logic want);
      if (r == 0) begin
         if (!v0 || xfer0_q) begin
            v0 = want; a0 = 4'($urandom); b0 = 4'($urandom); op0 = 3'($urandom);
         end
      end else begin
         if (!v1 || xfer1_q) begin
            v1 = want; a1 = 4'($urandom); b1 = 4'($urandom); op1 = 3'($urandom);
         end
      end
   endtask

   initial begin
      repeat (3) step;
      // Single request with hand-computed expectations: 0100 & 0110 = 0100.
      rst_n = 1'b1;
      v0 = 1'b1; a0 = 4'b0100; b0 = 4'b0110; op0 = 3'b010;
      @(negedge clk); chk("single_ready", rdy0_3, 1'b1);
      step; v0 = 1'b0;
      @(negedge clk); chk("single_alu_a", aa3, 4'b0100);
      step; @(negedge clk); chk("single_rsp_t2", rv0_3, 1'b0);
      step; @(negedge clk); chk("single_rsp_t3", rv0_3, 1'b0);
      step; @(negedge clk); chk("single_rsp_t4", rv0_3, 1'b1);
      chk("single_rsp_x", rx3, 4'b0100);
      chk("single_rsp1", rv1_3, 1'b0);
      repeat (2) step;

      // Round-robin under continuous dual requests.
      for (int i = 0; i < 6; i++) begin
         step;
         if (!v0 || xfer0_q) begin v0 = 1'b1; op0 = 3'(i); a0 = 4'($urandom); b0 = 4'($urandom); end
         if (!v1 || xfer1_q) begin v1 = 1'b1; op1 = 3'(7 - i); a1 = 4'($urandom); b1 = 4'($urandom); end
      end
      // Hold during dual requests, then release.
      step; hold = 1'b1;
      @(negedge clk); chk("hold_ready", {30'd0, rdy0_3, rdy1_3}, 32'd0);
      repeat (2) step;
      step; hold = 1'b0;
      repeat (3) begin step; refresh(0, 1'b1); refresh(1, 1'b1); end
      step; v0 = 1'b0; v1 = 1'b0;
      repeat (6) step;

      // Reset mid-flight.
      for (int i = 0; i < 3; i++) begin step; refresh(0, 1'b1); end
      step; v0 = 1'b0;
      step; rst_n = 1'b0;
      @(negedge clk); chk("rst_busy", busy3, 1'b0);
      chk("rst_alu_a", aa3, 4'd0);
      step; rst_n = 1'b1;
      repeat (6) step;

      // Single-side stream from req1, then a req0 pulse that loses.
      for (int i = 0; i < 8; i++) begin step; refresh(1, 1'b1); end
      step; v1 = 1'b0; refresh(0, 1'b1);
      step; refresh(0, 1'b1); refresh(1, 1'b1);
      @(negedge clk); chk("pulse_lose", rdy0_3, 1'b0);
      step; v0 = 1'b0; refresh(1, 1'b0);
      step; v1 = 1'b0;
      repeat (5) step;

      // Back-to-back opcodes 000..111 from req0.
      for (int i = 0; i < 8; i++) begin
         step; v0 = 1'b1; op0 = 3'(i); a0 = 4'($urandom); b0 = 4'($urandom);
      end
      step; v0 = 1'b0;
      repeat (6) step;

      // Randomized traffic with occasional hold, withdrawal and reset.
      for (int n = 0; n < 600; n++) begin
         step;
         rst_n = ($urandom_range(0, 99) != 0);
         hold  = ($urandom_range(0, 7) == 0);
         if (v0 && !xfer0_q) begin
            if ($urandom_range(0, 7) == 0) v0 = 1'b0;
         end else refresh(0, $urandom_range(0, 2) != 0);
         if (v1 && !xfer1_q) begin
            if ($urandom_range(0, 7) == 0) v1 = 1'b0;
         end else refresh(1, $urandom_range(0, 2) != 0);
      end
      step; rst_n = 1'b1; hold = 1'b0; v0 = 1'b0; v1 = 1'b0;
      repeat (8) step;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
